// File: rtl/div_unit_seq.sv
// div_unit_seq
//   Iterative radix-2 restoring divider for the RV32M DIV, DIVU, REM and REMU
//   instructions. It sits in the execute stage beside the ALU. The registered
//   result drives the divide leg of the writeback mux. The control unit stalls
//   the pipeline while busy is high.
//
//   Optional build macro: DIV_UNIT_EARLY_OUT_EN
//     When it is defined, three cases finish at the accepting edge and never
//     enter RUN: divide by zero, signed overflow and |a| < |b|.
//     When it is undefined, every operation runs all N iterations.
//     Both builds give bit-identical results.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous reset, active low
//   start   operation request; sampled only in IDLE or DONE
//   op      funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a       dividend (rs1)
//   b       divisor (rs2)
//   busy    high while iterating (RUN)
//   done    one-cycle pulse; result is valid
//   result  quotient or remainder; held until the next accepted start
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for start
// RUN   | one restoring iteration per clock; busy high
// DONE  | result loaded; done high for one cycle

module div_unit_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic           is_rem;
  logic [N-1:0]   quo;
  logic [N-1:0]   rem;
  logic [N-1:0]   dvs;
  logic [CW-1:0]  cnt;
  logic           neg_q;
  logic           neg_r;

  // Operand conditioning at the accepting edge.
  logic           is_signed;
  logic           a_neg;
  logic           b_neg;
  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic           b_zero;
  logic           take_early;
  logic [N-1:0]   early_res;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[N-1];
  assign b_neg     = is_signed & b[N-1];
  assign mag_a     = a_neg ? (~a + 1'b1) : a;
  assign mag_b     = b_neg ? (~b + 1'b1) : b;
  assign b_zero    = (b == '0);

`ifdef DIV_UNIT_EARLY_OUT_EN
  logic ovf;
  logic a_lt_b;

  assign ovf    = is_signed && (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
  assign a_lt_b = (mag_a < mag_b);

  assign take_early = b_zero | ovf | a_lt_b;

  // The zero-divisor case is tested first. Overflow cannot coincide with
  // |a| < |b|, because |a| = 2^(N-1) and |b| = 1 in that case.
  always_comb begin
    early_res = '0;
    if (b_zero) begin
      early_res = op[1] ? a : '1;
    end else if (ovf) begin
      early_res = op[1] ? '0 : {1'b1, {(N-1){1'b0}}};
    end else begin
      early_res = op[1] ? a : '0;
    end
  end
`else
  assign take_early = 1'b0;
  assign early_res  = '0;
`endif

  // One restoring step. The invariant rem < dvs holds throughout, so bit N of
  // the N+1-bit difference is a clean borrow flag. A zero divisor also needs
  // no special case here: every trial succeeds, so the quotient becomes all
  // ones and the remainder becomes |a|.
  logic [N:0]   shifted;
  logic [N:0]   diff;
  logic         fits;
  logic [N-1:0] rem_nx;
  logic [N-1:0] quo_nx;
  logic [N-1:0] quo_fix;
  logic [N-1:0] rem_fix;
  logic [N-1:0] final_res;

  assign shifted   = {rem, quo[N-1]};
  assign diff      = shifted - {1'b0, dvs};
  assign fits      = ~diff[N];
  assign rem_nx    = fits ? diff[N-1:0] : shifted[N-1:0];
  assign quo_nx    = {quo[N-2:0], fits};
  assign quo_fix   = neg_q ? (~quo_nx + 1'b1) : quo_nx;
  assign rem_fix   = neg_r ? (~rem_nx + 1'b1) : rem_nx;
  assign final_res = is_rem ? rem_fix : quo_fix;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      is_rem <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            is_rem <= op[1];
            quo    <= mag_a;
            dvs    <= mag_b;
            rem    <= '0;
            // A zero divisor must still give an all-ones quotient, so the
            // quotient sign is dropped in that case.
            neg_q  <= (a_neg ^ b_neg) & ~b_zero;
            neg_r  <= a_neg;
            if (take_early) begin
              cnt    <= '0;
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= early_res;
            end else begin
              cnt   <= CW'(N);
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end

        RUN: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= final_res;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit_seq.sv
module tb_div_unit_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

`ifdef DIV_UNIT_EARLY_OUT_EN
  localparam int EL = 0;
`else
  localparam int EL = 32;
`endif

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  div_unit_seq #(.N(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one request and returns how many edges after the accepting edge
  // done was first seen (-1 on timeout).
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic [31:0] res,
                       output logic overlap, output logic busy0);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk); #1;
    start   = 1'b0;
    a       = $urandom;
    b       = $urandom;
    busy0   = busy;
    overlap = busy & done;
    lat     = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      overlap = overlap | (busy & done);
    end
    if (!done) lat = -1;
    res = result;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    #20;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors(input string tag, input vec_t v[6]);
    int lat; logic [31:0] r; logic ov; logic b0;
    for (int i = 0; i < 6; i++) begin
      issue(v[i].op, v[i].a, v[i].b, lat, r, ov, b0);
      checks++; if (r !== v[i].exp) begin errors++; $display("FAIL %s_%s result got %h want %h", tag, v[i].name, r, v[i].exp); end
      checks++; if (lat != v[i].lat) begin errors++; $display("FAIL %s_%s latency got %0d want %0d", tag, v[i].name, lat, v[i].lat); end
      checks++; if (b0 !== (v[i].lat != 0)) begin errors++; $display("FAIL %s_%s busy_after_accept got %b want %b", tag, v[i].name, b0, v[i].lat != 0); end
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL %s_%s busy_done_overlap got %b want 0", tag, v[i].name, ov); end
      @(negedge clk);
    end
  endtask

  task automatic test_unsigned();
    vec_t v[6] = '{
      '{OP_DIVU, 32'd100,        32'd7,          32'd14,         32, "divu_100_7"},
      '{OP_REMU, 32'd100,        32'd7,          32'd2,          32, "remu_100_7"},
      '{OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32, "divu_max_1"},
      '{OP_REMU, 32'hFFFFFFFF,   32'd1,          32'd0,          32, "remu_max_1"},
      '{OP_DIVU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32, "divu_max_max"},
      '{OP_REMU, 32'hFFFFFFFE,   32'd3,          32'd2,          32, "remu_big_3"}
    };
    test_vectors("unsigned", v);
  endtask

  task automatic test_signed();
    vec_t v[6] = '{
      '{OP_DIV, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD, 32, "div_m7_2"},
      '{OP_REM, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32, "rem_m7_2"},
      '{OP_DIV, 32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD, 32, "div_7_m2"},
      '{OP_REM, 32'd7,        32'hFFFFFFFE,   32'd1,        32, "rem_7_m2"},
      '{OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE,   32'd3,        32, "div_m7_m2"},
      '{OP_REM, 32'hFFFFFFF9, 32'hFFFFFFFE,   32'hFFFFFFFF, 32, "rem_m7_m2"}
    };
    test_vectors("signed", v);
  endtask

  task automatic test_div_zero();
    vec_t v[6] = '{
      '{OP_DIVU, 32'd5,        32'd0, 32'hFFFFFFFF, EL, "divu_5_0"},
      '{OP_REMU, 32'd5,        32'd0, 32'd5,        EL, "remu_5_0"},
      '{OP_DIV,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, EL, "div_m5_0"},
      '{OP_REM,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, EL, "rem_m5_0"},
      '{OP_DIV,  32'd5,        32'd0, 32'hFFFFFFFF, EL, "div_5_0"},
      '{OP_REMU, 32'h0,        32'd0, 32'h0,        EL, "remu_0_0"}
    };
    test_vectors("divzero", v);
  endtask

  task automatic test_overflow_small();
    vec_t v[6] = '{
      '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, EL, "div_ovf"},
      '{OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0,        EL, "rem_ovf"},
      '{OP_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, EL, "remu_lt"},
      '{OP_DIVU, 32'd3,        32'd10,       32'h0,        EL, "divu_3_10"},
      '{OP_DIV,  32'hFFFFFFFD, 32'hFFFFFFF6, 32'h0,        EL, "div_m3_m10"},
      '{OP_REM,  32'hFFFFFFFD, 32'd10,       32'hFFFFFFFD, EL, "rem_m3_10"}
    };
    test_vectors("early", v);
  endtask

  task automatic test_start_ignored();
    int lat;
    start = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    repeat (4) begin @(posedge clk); #1; lat++; end
    start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3;
    @(posedge clk); #1; lat++;
    start = 1'b0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!done) lat = -1;
    checks++; if (result !== 32'd10) begin errors++; $display("FAIL ignore_start result got %h want %h", result, 32'd10); end
    checks++; if (lat != 32) begin errors++; $display("FAIL ignore_start latency got %0d want 32", lat); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; logic [31:0] r1, r2; logic ov1, ov2, b01, b02;
    issue(OP_DIV, 32'd20, 32'hFFFFFFFD, lat1, r1, ov1, b01);
    issue(OP_REM, 32'd20, 32'hFFFFFFFD, lat2, r2, ov2, b02);
    checks++; if (r1 !== 32'hFFFFFFFA) begin errors++; $display("FAIL b2b_div result got %h want fffffffa", r1); end
    checks++; if (lat1 != 32) begin errors++; $display("FAIL b2b_div latency got %0d want 32", lat1); end
    checks++; if (r2 !== 32'd2) begin errors++; $display("FAIL b2b_rem result got %h want 2", r2); end
    checks++; if (lat2 != 32) begin errors++; $display("FAIL b2b_rem latency got %0d want 32", lat2); end
    checks++; if (b02 !== 1'b1) begin errors++; $display("FAIL b2b_no_idle busy got %b want 1", b02); end
    checks++; if ((ov1 | ov2) !== 1'b0) begin errors++; $display("FAIL b2b_overlap got %b want 0", ov1 | ov2); end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [31:0] r; logic ov, b0;
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy_before got %b want 1", busy); end
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrun_reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrun_reset_done got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL midrun_reset_result got %h want 0", result); end
    #20;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    issue(OP_DIVU, 32'd9, 32'd3, lat, r, ov, b0);
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL after_reset result got %h want 3", r); end
    checks++; if (lat != 32) begin errors++; $display("FAIL after_reset latency got %0d want 32", lat); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow_small();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
